// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame
// geometry and the system clock / baud constants used by rx, tx and bench.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DATA_BITS_DEF  = 8;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int CLK_HZ         = 50_000_000;
   localparam int BAUD           = 115200;

   // Clock cycles between oversample enables (27 at 50 MHz / 115200).
   function automatic int baud_div();
      return CLK_HZ / (BAUD * OVERSAMPLE_DEF);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bundle: received byte, sticky status flags and
// the consumer's clear. master = receiver side, slave = consumer side.
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) ();

   logic                 rdy_clr;
   logic [DATA_BITS-1:0] data;
   logic                 rdy;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      input  rdy_clr,
      output data,
      output rdy,
      output frame_err,
      output overrun
   );

   modport slave (
      output rdy_clr,
      input  data,
      input  rdy,
      input  frame_err,
      input  overrun
   );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with parameterised reset value.
// Ports: clk, rst_n (async low), d (async in), q (synchronised out).
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit start validation,
// sticky rdy / frame_err / overrun cleared by bus.rdy_clr.
// Ports: clk_50mhz, rst_n, rxclk_en (oversample tick), rx, bus (master).
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic      clk_50mhz,
   input  logic      rst_n,
   input  logic      rxclk_en,
   input  logic      rx,
   uart_rx_if.master bus
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   state_t               state, state_nxt;
   logic [SW-1:0]        sample_cnt, sample_nxt;
   logic [BW-1:0]        bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 byte_done;
   logic                 ferr_set;
   logic                 rx_s;

   logic [DATA_BITS-1:0] data_q;
   logic                 rdy_q;
   logic                 ferr_q;
   logic                 ovr_q;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk_50mhz),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
      end else begin
         state      <= state_nxt;
         sample_cnt <= sample_nxt;
         bit_cnt    <= bit_nxt;
         shreg      <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      sample_nxt = sample_cnt;
      bit_nxt    = bit_cnt;
      shreg_nxt  = shreg;
      byte_done  = 1'b0;
      ferr_set   = 1'b0;
      if (rxclk_en) begin
         unique case (state)
            IDLE: begin
               sample_nxt = '0;
               if (!rx_s) state_nxt = START;
            end
            START: begin
               if (sample_cnt == HALF_LAST) begin
                  sample_nxt = '0;
                  bit_nxt    = '0;
                  // A start bit that is gone by mid-bit was a glitch.
                  state_nxt  = rx_s ? IDLE : DATA;
               end else begin
                  sample_nxt = sample_cnt + 1'b1;
               end
            end
            DATA: begin
               if (sample_cnt == FULL_LAST) begin
                  sample_nxt = '0;
                  // Right shift: first (LSB) bit ends up in bit 0.
                  shreg_nxt  = {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BIT_LAST) state_nxt = STOP;
                  else bit_nxt = bit_cnt + 1'b1;
               end else begin
                  sample_nxt = sample_cnt + 1'b1;
               end
            end
            STOP: begin
               if (sample_cnt == FULL_LAST) begin
                  sample_nxt = '0;
                  state_nxt  = IDLE;
                  byte_done  = rx_s;
                  ferr_set   = !rx_s;
               end else begin
                  sample_nxt = sample_cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Flags: a set event in the same cycle as rdy_clr takes priority.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         rdy_q  <= 1'b0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (byte_done) begin
            data_q <= shreg;
            rdy_q  <= 1'b1;
         end else if (bus.rdy_clr) begin
            rdy_q  <= 1'b0;
         end
         if (ferr_set)         ferr_q <= 1'b1;
         else if (bus.rdy_clr) ferr_q <= 1'b0;
         if (byte_done && rdy_q) ovr_q <= 1'b1;
         else if (bus.rdy_clr)   ovr_q <= 1'b0;
      end
   end

   assign bus.data      = data_q;
   assign bus.rdy       = rdy_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver directly downstream of the baud generator; consumes its 16x-oversample enable `rxclk_en` (one `clk_50mhz` cycle wide, nominally every 27 cycles for 115200 baud).
- Synchronises the asynchronous `rx` line and validates the start bit at mid-bit.
- Samples 8N1 frames LSB first and presents each byte with a sticky ready flag, cleared by the consumer. Framing-error and overrun status accompany the byte.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- OVERSAMPLE, 16, `rxclk_en` ticks per bit period; must be even and ≥ 4.

Ports:
- clk_50mhz  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rxclk_en  input  1  oversample enable, one clock wide.
- rx  input  1  asynchronous serial line, idle high.
- rdy_clr  input  1  consumer acknowledge; clears `rdy`, `frame_err` and `overrun`.
- data  output  DATA_BITS  last received byte.
- rdy  output  1  byte available (sticky).
- frame_err  output  1  last frame had stop bit = 0 (sticky).
- overrun  output  1  a byte completed while `rdy` was still 1 (sticky).

Behaviour:
- **Reset.** Asynchronous on `rst_n` low:
  - state = IDLE; sample_cnt = 0; bit_cnt = 0; shift register = 0.
  - Synchroniser flops = 1.
  - `data` = 0, `rdy` = 0, `frame_err` = 0, `overrun` = 0.
  - Reset mid-frame abandons the frame; nothing is reported.
- **Synchroniser.** `rx` passes through 2 flops, clocked every clk (not gated by `rxclk_en`); `rx_s` is the second flop. The FSM uses only `rx_s`.
- **Tick gating.** All FSM and counter updates happen only on cycles with `rxclk_en` = 1. Exceptions: `rdy_clr` handling and reset.
- **FSM.**
  - IDLE: sample_cnt = 0. If `rx_s` = 0 on a tick → START.
  - START: sample_cnt increments each tick. At sample_cnt = OVERSAMPLE/2 − 1 (7):
    - if `rx_s` = 0 → DATA, sample_cnt = 0, bit_cnt = 0;
    - else → IDLE (glitch rejected, no flags set).
  - DATA: sample_cnt increments each tick. At sample_cnt = OVERSAMPLE − 1 (15):
    - shift `rx_s` into the MSB of the shift register (right shift, so LSB-first arrival ends LSB-aligned);
    - sample_cnt = 0; bit_cnt += 1;
    - after bit_cnt reaches DATA_BITS − 1 and that bit is sampled → STOP.
  - STOP: at sample_cnt = 15, sample `rx_s`:
    - 1: `data` ← shift register; `rdy` ← 1; `overrun` ← 1 if `rdy` was already 1; `frame_err` unchanged.
    - 0: `frame_err` ← 1; `data` and `rdy` unchanged.
    - Either way → IDLE.
- **Latency.**
  - `rdy` rises on the clk edge of the stop-bit mid-sample tick.
  - End to end: ≈ 9.5 bit periods after the start edge, plus 2 clk of synchroniser delay.
- **rdy_clr.** Evaluated every clk, regardless of `rxclk_en`; clears all three flags on the next edge. If a set event (new byte, frame error) happens in the same cycle, the set wins for that flag.
- **Back-to-back frames.** IDLE is re-entered at the stop-bit mid-sample. A start edge arriving in the second half of the stop bit is detected without loss.
- **Idle low line (break).**
  - The frame yields `frame_err` = 1, then the FSM returns to IDLE.
  - It immediately sees `rx_s` = 0 and re-enters START. Repeated frame errors are acceptable and not deduplicated.
- **Counter widths.**
  - sample_cnt: $clog2(OVERSAMPLE) bits.
  - bit_cnt: $clog2(DATA_BITS) bits; wrap cannot occur because terminal compares precede increment.

Decomposition:
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, 2-bit encoding);
  - the constants DATA_BITS_DEF = 8 and OVERSAMPLE_DEF = 16;
  - CLK_HZ = 50_000_000 and BAUD = 115200, for reuse by the transmitter and bench.
- One natural sub-module: `sync_2ff`, a 1-bit two-flop synchroniser with async active-low reset to a parameterised reset value (1 here).

Test Plan:
- **Normal byte.** Real baud generator drives `rxclk_en`; send 0xA5 as 8N1 at 115200 baud → `rdy` = 1, `data` = 0xA5, `frame_err` = 0, `overrun` = 0; `rdy_clr` pulse → `rdy` = 0 next clk.
- **Glitch rejection.** `rx` low for 3 oversample ticks (~81 clk), then high → FSM returns to IDLE; no flags set and `data` unchanged. Then send 0x3C → `data` = 0x3C.
- **Framing error.** Send 0x55 with stop bit = 0 → `frame_err` = 1, `rdy` = 0, `data` keeps its previous value. Then send 0x0F with a valid stop bit → `rdy` = 1, `data` = 0x0F, `frame_err` still 1 until `rdy_clr`.
- **Overrun.** Back-to-back 0x11 then 0x22 with no `rdy_clr` → `data` = 0x22, `overrun` = 1. Assert `rdy_clr` on the same clk as a third byte (0x33) completes → `rdy` = 1, `overrun` = 1 (set wins), `data` = 0x33.
- **Reset mid-frame.** Assert `rst_n` low during data bit 4 of 0xFF, then release with `rx` high → all outputs 0, state IDLE. The next frame, 0x81, is received correctly.
- **Baud tolerance.** 0x96 sent with bit period +3% and −3% of nominal → `data` = 0x96 and `frame_err` = 0 in both cases.
